// File: rtl/sprite_pkg.sv
// Shared encodings for the sprite character controller: action/facing codes,
// draw FSM states and the sprite-atlas base lookup.
package sprite_pkg;

  typedef enum logic [2:0] {
    NoAction = 3'd0,
    Attack   = 3'd1,
    DirUp    = 3'd2,
    DirDown  = 3'd3,
    DirLeft  = 3'd4,
    DirRight = 3'd5
  } dir_e;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StFlush,
    StDone
  } state_e;

  // Atlas is 64x64: normal poses 16x16 in rows 0/16 (by frame), attack poses below.
  function automatic logic [11:0] atlas_base(input logic attack, input dir_e facing,
                                             input logic frame);
    logic [5:0] bx;
    logic [5:0] by;
    bx = 6'd0;
    by = 6'd0;
    if (attack) begin
      case (facing)
        DirUp:   begin bx = 6'd0;  by = 6'd32; end
        DirDown: begin bx = 6'd16; by = 6'd32; end
        DirLeft: begin bx = 6'd32; by = 6'd32; end
        default: begin bx = 6'd32; by = 6'd48; end
      endcase
    end else begin
      case (facing)
        DirUp:   bx = 6'd0;
        DirDown: bx = 6'd16;
        DirLeft: bx = 6'd32;
        default: bx = 6'd48;
      endcase
      by = frame ? 6'd16 : 6'd0;
    end
    return {bx, by};
  endfunction

endpackage

// File: rtl/sprite_raster_ctr.sv
// Row-major column/row raster counter with a flag on the final position.
module sprite_raster_ctr #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] last_col,
  input  logic [CNT_W-1:0] last_row,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             last
);

  logic col_end;

  assign col_end = (col == last_col);
  assign last    = col_end && (row == last_row);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (enable) begin
      if (col_end) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_char.sv
// Player/NPC sprite controller: command register, collision-checked movement and
// sprite streaming from a 1-cycle-latency ROM to the VGA pixel writer.
module sprite_char
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W        = 16,
  parameter int unsigned SPR_H        = 16,
  parameter int unsigned ATK_EXT      = 16,
  parameter int unsigned X_W          = 9,
  parameter int unsigned Y_W          = 8,
  parameter int unsigned COL_W        = 6,
  parameter int unsigned STEP         = 1,
  parameter int unsigned X_INIT       = 1,
  parameter int unsigned Y_INIT       = 96,
  parameter int unsigned X_MAX        = 320,
  parameter int unsigned Y_MAX        = 240,
  parameter int unsigned ATK_COOLDOWN = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             c_attack,
  input  logic             c_up,
  input  logic             c_down,
  input  logic             c_left,
  input  logic             c_right,
  input  logic             init,
  input  logic             reg_action,
  input  logic             apply_action,
  input  logic             draw,
  input  logic [3:0]       collision,
  input  logic [COL_W-1:0] rom_q,
  output logic [5:0]       rom_x,
  output logic [5:0]       rom_y,
  output logic [X_W-1:0]   x_pos,
  output logic [Y_W-1:0]   y_pos,
  output logic [X_W-1:0]   x_draw,
  output logic [Y_W-1:0]   y_draw,
  output logic [COL_W-1:0] colour,
  output logic [2:0]       direction,
  output logic [2:0]       facing,
  output logic             VGA_write,
  output logic             draw_done
);

  localparam int unsigned SPR_MAX = (SPR_W > SPR_H) ? SPR_W : SPR_H;
  localparam int unsigned CNT_W   = $clog2(SPR_MAX + ATK_EXT + 1);
  localparam int unsigned CD_W    = $clog2(ATK_COOLDOWN + 1);
  localparam int unsigned X_LIM   = X_MAX - SPR_W;
  localparam int unsigned Y_LIM   = Y_MAX - SPR_H;
  localparam logic [COL_W-1:0] TRANSP = '1;

  state_e           state_q;
  dir_e             direction_q, facing_q, cmd;
  logic [X_W-1:0]   x_pos_q, x_draw_q, org_x, nx;
  logic [Y_W-1:0]   y_pos_q, y_draw_q, org_y, ny;
  logic             frame_q, wr_valid_q, draw_done_q, move_ok, attack_pose;
  logic [CD_W-1:0]  cooldown_q;
  logic [CNT_W-1:0] col, row, last_col, last_row;
  logic             raster_last;
  logic [11:0]      base;

  assign attack_pose = (direction_q == Attack);

  // Attack poses extend the draw region; up/left extensions move the origin back.
  always_comb begin
    org_x    = x_pos_q;
    org_y    = y_pos_q;
    last_col = CNT_W'(SPR_W - 1);
    last_row = CNT_W'(SPR_H - 1);
    if (attack_pose) begin
      case (facing_q)
        DirUp: begin
          org_y    = y_pos_q - Y_W'(ATK_EXT);
          last_row = CNT_W'(SPR_H + ATK_EXT - 1);
        end
        DirDown: last_row = CNT_W'(SPR_H + ATK_EXT - 1);
        DirLeft: begin
          org_x    = x_pos_q - X_W'(ATK_EXT);
          last_col = CNT_W'(SPR_W + ATK_EXT - 1);
        end
        default: last_col = CNT_W'(SPR_W + ATK_EXT - 1);
      endcase
    end
  end

  always_comb begin
    cmd = NoAction;
    if (c_attack && (cooldown_q == '0)) cmd = Attack;
    else if (c_up)                      cmd = DirUp;
    else if (c_down)                    cmd = DirDown;
    else if (c_left)                    cmd = DirLeft;
    else if (c_right)                   cmd = DirRight;
  end

  // Moves are all-or-nothing: a step that would leave the screen is dropped.
  always_comb begin
    move_ok = 1'b0;
    nx      = x_pos_q;
    ny      = y_pos_q;
    case (direction_q)
      DirUp: begin
        move_ok = !collision[0] && (32'(y_pos_q) >= STEP);
        ny      = y_pos_q - Y_W'(STEP);
      end
      DirDown: begin
        move_ok = !collision[1] && (32'(y_pos_q) + STEP <= Y_LIM);
        ny      = y_pos_q + Y_W'(STEP);
      end
      DirLeft: begin
        move_ok = !collision[2] && (32'(x_pos_q) >= STEP);
        nx      = x_pos_q - X_W'(STEP);
      end
      DirRight: begin
        move_ok = !collision[3] && (32'(x_pos_q) + STEP <= X_LIM);
        nx      = x_pos_q + X_W'(STEP);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || init) begin
      x_pos_q     <= X_W'(X_INIT);
      y_pos_q     <= Y_W'(Y_INIT);
      facing_q    <= DirDown;
      direction_q <= NoAction;
      frame_q     <= 1'b0;
      cooldown_q  <= '0;
    end else if (state_q != StDraw) begin
      if (reg_action) direction_q <= cmd;
      if (apply_action) begin
        if (cooldown_q != '0) cooldown_q <= cooldown_q - 1'b1;
        case (direction_q)
          Attack: cooldown_q <= CD_W'(ATK_COOLDOWN);
          DirUp, DirDown, DirLeft, DirRight: begin
            facing_q <= direction_q;
            if (move_ok) begin
              x_pos_q <= nx;
              y_pos_q <= ny;
              frame_q <= ~frame_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || init) begin
      state_q     <= StIdle;
      wr_valid_q  <= 1'b0;
      draw_done_q <= 1'b0;
      x_draw_q    <= '0;
      y_draw_q    <= '0;
    end else begin
      draw_done_q <= 1'b0;
      wr_valid_q  <= (state_q == StDraw);
      // Coordinates are staged one cycle to line up with the ROM read data.
      if (state_q == StDraw) begin
        x_draw_q <= org_x + X_W'(col);
        y_draw_q <= org_y + Y_W'(row);
      end
      case (state_q)
        StIdle: if (draw) state_q <= StDraw;
        StDraw: begin
          if (raster_last) begin
            state_q     <= StFlush;
            draw_done_q <= 1'b1;
          end
        end
        StFlush: state_q <= StDone;
        default: if (!draw) state_q <= StIdle;
      endcase
    end
  end

  sprite_raster_ctr #(
    .CNT_W(CNT_W)
  ) u_raster (
    .clock    (clock),
    .reset    (reset),
    .clear    (init || (state_q != StDraw)),
    .enable   (state_q == StDraw),
    .last_col (last_col),
    .last_row (last_row),
    .col      (col),
    .row      (row),
    .last     (raster_last)
  );

  assign base      = atlas_base(attack_pose, facing_q, frame_q);
  assign rom_x     = base[11:6] + 6'(col);
  assign rom_y     = base[5:0] + 6'(row);
  assign x_pos     = x_pos_q;
  assign y_pos     = y_pos_q;
  assign x_draw    = x_draw_q;
  assign y_draw    = y_draw_q;
  assign colour    = rom_q;
  assign direction = direction_q;
  assign facing    = facing_q;
  assign VGA_write = wr_valid_q && (rom_q != TRANSP);
  assign draw_done = draw_done_q;

endmodule
